// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub
//   Two's-complement adder/subtractor whose carry chain is cut into CHUNK-bit
//   segments, one segment per pipeline stage (STAGES = WIDTH/CHUNK). Operands
//   travel down skew registers until their segment is resolved. Finished low
//   result segments travel along with them, so every segment of one operation
//   leaves the last stage in the same cycle. One global advance enable moves
//   every stage at once, bubbles included, and freezes the whole pipe under
//   backpressure.
//   WIDTH must be a multiple of CHUNK, and STAGES must be at least 1.
//
// Ports
//   clk       rising-edge clock
//   reset_n   synchronous active-low reset
//   in_valid  operand set on a/b/sub/carry_in is valid
//   in_ready  operand set is accepted this cycle (reset_n && advance)
//   a, b      operands
//   sub       0 = add, 1 = subtract
//   carry_in  carry-in (add) or borrow-in (subtract)
//   out_valid result on sum/carry/overflow is valid
//   out_ready consumer takes the result this cycle
//   sum       result modulo 2^WIDTH
//   carry     unsigned carry-out (subtract: 1 = no borrow)
//   overflow  signed overflow
module pipelined_add_sub #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int STAGES = WIDTH / CHUNK;

  logic adv_s;

  // The pipe moves as one unit: it shifts unless a finished result is stuck.
  assign adv_s    = !out_valid || out_ready;
  assign in_ready = reset_n && adv_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Stage k still needs operand bits from segment k upward.
    logic [WIDTH-1:k*CHUNK]   a_in_s;
    logic [WIDTH-1:k*CHUNK]   b_in_s;
    logic                     c_in_s;
    logic                     v_in_s;
    logic [CHUNK:0]           chunk_s;
    logic [(k+1)*CHUNK-1:0]   sum_nxt_s;
    logic [(k+1)*CHUNK-1:0]   sum_r;
    logic                     cy_r;
    logic                     valid_r;

    if (k == 0) begin : g_head
      // Operands enter here. B is inverted once, and the carry seed is folded in.
      always_comb begin
        a_in_s = a;
        b_in_s = b ^ {WIDTH{sub}};
        c_in_s = carry_in ^ sub;
        v_in_s = in_valid && in_ready;
      end

      // The first segment starts the result vector.
      always_comb begin
        sum_nxt_s = chunk_s[CHUNK-1:0];
      end
    end else begin : g_tail
      // Take the skewed operands, the partial result and the carry from stage k-1.
      always_comb begin
        a_in_s = g_stage[k-1].g_skew.opa_r;
        b_in_s = g_stage[k-1].g_skew.opb_r;
        c_in_s = g_stage[k-1].cy_r;
        v_in_s = g_stage[k-1].valid_r;
      end

      // Append this segment above the already resolved lower segments.
      always_comb begin
        sum_nxt_s = {chunk_s[CHUNK-1:0], g_stage[k-1].sum_r};
      end
    end

    // One CHUNK-bit slice of the carry chain, with its carry-out in the top bit.
    always_comb begin
      chunk_s = {1'b0, a_in_s[k*CHUNK +: CHUNK]}
              + {1'b0, b_in_s[k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, c_in_s};
    end

    // Result, carry and valid registers for this stage.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        valid_r <= 1'b0;
        sum_r   <= '0;
        cy_r    <= 1'b0;
      end else if (adv_s) begin
        valid_r <= v_in_s;
        sum_r   <= sum_nxt_s;
        cy_r    <= chunk_s[CHUNK];
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:(k+1)*CHUNK] opa_r;
      logic [WIDTH-1:(k+1)*CHUNK] opb_r;

      // Carry the still unused upper operand segments forward to later stages.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          opa_r <= '0;
          opb_r <= '0;
        end else if (adv_s) begin
          opa_r <= a_in_s[WIDTH-1:(k+1)*CHUNK];
          opb_r <= b_in_s[WIDTH-1:(k+1)*CHUNK];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_nxt_s;
      logic ovf_r;

      // The carry into the MSB is recovered as a^b^sum at the MSB.
      always_comb begin
        ovf_nxt_s = a_in_s[WIDTH-1] ^ b_in_s[WIDTH-1]
                  ^ chunk_s[CHUNK-1] ^ chunk_s[CHUNK];
      end

      // Registered signed-overflow flag, aligned with the final segment.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          ovf_r <= 1'b0;
        end else if (adv_s) begin
          ovf_r <= ovf_nxt_s;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_r;
  assign sum       = g_stage[STAGES-1].sum_r;
  assign carry     = g_stage[STAGES-1].cy_r;
  assign overflow  = g_stage[STAGES-1].g_last.ovf_r;

endmodule

// File: tb/tb_pipelined_add_sub.sv
module tb_pipelined_add_sub;

  logic        clk;
  logic        reset_n;

  // 64-bit, 4-stage instance
  logic        in_valid, in_ready, sub, carry_in, out_valid, out_ready, carry, overflow;
  logic [63:0] a, b, sum;

  // 8-bit, single-stage instance
  logic        in_valid8, in_ready8, sub8, carry_in8, out_valid8, out_ready8, carry8, overflow8;
  logic [7:0]  a8, b8, sum8;

  int checks = 0;
  int errors = 0;

  pipelined_add_sub dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .carry_in(carry_in), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry(carry), .overflow(overflow)
  );

  pipelined_add_sub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .carry_in(carry_in8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .carry(carry8), .overflow(overflow8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated operation through the 4-stage pipe, checking latency and result.
  task automatic op64(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                      input logic tsub, input logic tcin,
                      input logic [63:0] esum, input logic ecy, input logic eovf);
    a = ta; b = tb; sub = tsub; carry_in = tcin; in_valid = 1'b1;
    #1 chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_latency"}, {63'd0, out_valid}, 64'd0);
      step();
    end
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_sum"}, sum, esum);
    chk({tag, "_carry"}, {63'd0, carry}, {63'd0, ecy});
    chk({tag, "_ovf"}, {63'd0, overflow}, {63'd0, eovf});
  endtask

  // One operation through the single-stage instance.
  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                     input logic tsub, input logic tcin,
                     input logic [7:0] esum, input logic ecy, input logic eovf);
    a8 = ta; b8 = tb; sub8 = tsub; carry_in8 = tcin; in_valid8 = 1'b1;
    #1 chk({tag, "_in_ready"}, {63'd0, in_ready8}, 64'd1);
    step();
    in_valid8 = 1'b0;
    chk({tag, "_valid"}, {63'd0, out_valid8}, 64'd1);
    chk({tag, "_sum"}, {56'd0, sum8}, {56'd0, esum});
    chk({tag, "_carry"}, {63'd0, carry8}, {63'd0, ecy});
    chk({tag, "_ovf"}, {63'd0, overflow8}, {63'd0, eovf});
    step();
    chk({tag, "_drain"}, {63'd0, out_valid8}, 64'd0);
  endtask

  initial begin
    // Reset held for two cycles with valid operands presented
    reset_n = 1'b0; out_ready = 1'b1; out_ready8 = 1'b1;
    in_valid = 1'b1; a = 64'd5; b = 64'd7; sub = 1'b0; carry_in = 1'b0;
    in_valid8 = 1'b1; a8 = 8'd5; b8 = 8'd7; sub8 = 1'b0; carry_in8 = 1'b0;
    step();
    step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", sum, 64'd0);
    chk("rst_carry", {63'd0, carry}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst8_out_valid", {63'd0, out_valid8}, 64'd0);
    chk("rst8_in_ready", {63'd0, in_ready8}, 64'd0);

    in_valid = 1'b0; in_valid8 = 1'b0; reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_nothing_accepted", {63'd0, out_valid}, 64'd0);
    end

    // Directed arithmetic cases, 64-bit
    op64("unsigned_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    op64("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
         64'h8000_0000_0000_0000, 1'b0, 1'b1);
    op64("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    op64("sub_noborrow", 64'd7, 64'd5, 1'b1, 1'b0, 64'd2, 1'b1, 1'b0);
    op64("sub_borrow_in", 64'd7, 64'd5, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0);
    op64("zero_minus_one", 64'd0, 64'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    op64("sub_neg_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0,
         64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    op64("add_carry_in", 64'h0000_0000_0000_FFFF, 64'd0, 1'b0, 1'b1,
         64'h0000_0000_0001_0000, 1'b0, 1'b0);

    // Backpressure: eight back-to-back adds i + 100 with a 3-cycle stall
    sub = 1'b0; carry_in = 1'b0; b = 64'd100; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 64'(i);
      #1 chk("bp_in_ready_fill", {63'd0, in_ready}, 64'd1);
      step();
      if (i < 3) chk("bp_fill_not_valid", {63'd0, out_valid}, 64'd0);
    end
    chk("bp_first_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_first_sum", sum, 64'd100);
    a = 64'd4;
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1 chk("bp_stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_stall_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_stall_sum_held", sum, 64'd100);
      step();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    chk("bp_release_sum", sum, 64'd100);
    for (int i = 4; i < 8; i++) begin
      a = 64'(i);
      step();
      chk("bp_stream_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_stream_sum", sum, 64'(97 + i));
      if (i < 7) chk("bp_stream_in_ready", {63'd0, in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    for (int j = 5; j < 8; j++) begin
      step();
      chk("bp_drain_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_drain_sum", sum, 64'(100 + j));
    end
    step();
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // Reset pulse with three operations in flight
    b = 64'd1; in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a = 64'(10 * i);
      step();
    end
    in_valid = 1'b0; reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("midrst_cleared", {63'd0, out_valid}, 64'd0);
    chk("midrst_sum_zero", sum, 64'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_no_stale", {63'd0, out_valid}, 64'd0);
    end
    op64("post_rst_add", 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0);

    // Single-stage instance, same directed cases
    op8("w8_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("w8_signed_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("w8_sub_borrow", 8'd5, 8'd7, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    op8("w8_sub_noborrow", 8'd7, 8'd5, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0);
    op8("w8_sub_borrow_in", 8'd7, 8'd5, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0);

    // Single-stage stall holds the result
    a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; carry_in8 = 1'b0; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0; out_ready8 = 1'b0;
    #1 chk("w8_stall_in_ready", {63'd0, in_ready8}, 64'd0);
    step();
    chk("w8_stall_valid", {63'd0, out_valid8}, 64'd1);
    chk("w8_stall_sum", {56'd0, sum8}, 64'h30);
    out_ready8 = 1'b1;
    step();
    chk("w8_stall_drain", {63'd0, out_valid8}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
